// File: rtl/password_pkg.sv
// Shared types and default sizes for the password store/checker.
package password_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        CMP    = 3'd2,
        RESULT = 3'd3,
        LOCK   = 3'd4
    } state_t;

endpackage

// File: rtl/password_ram.sv
// Single-clock password memory with read-first behaviour and one-cycle read latency.
// The read data register only updates on a read strobe, so it holds steady for later stages.
module password_ram
    import password_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write and read in one block; both use non-blocking updates, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/password_check.sv
// Password checker: valid bits, check FSM, consecutive-failure counter and timed lockout.
// The stored words live in password_ram; an entry only matches once it has been provisioned.
module password_check
    import password_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wren,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             chk_valid,
    output logic                             chk_ready,
    input  logic [ADDR_W-1:0]                chk_addr,
    input  logic [DATA_W-1:0]                chk_data,
    output logic                             res_valid,
    output logic                             res_match,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_TRIES);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic [DEPTH-1:0]    r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_ramQ;
    logic [FAIL_W-1:0]   r_failCount;
    logic [LOCK_W-1:0]   r_lockCount;
    logic                r_resValid;
    logic                r_resMatch;
    logic                w_accept;
    logic                w_match;
    logic                w_lockDone;

    assign w_accept   = chk_valid && (r_state == IDLE);
    assign w_match    = (w_ramQ == r_data) && r_valid[r_addr];
    assign w_lockDone = (r_state == LOCK) && (r_lockCount == '0);

    assign res_valid  = r_resValid;
    assign res_match  = r_resMatch;
    assign fail_count = r_failCount;

    // The read is launched on the acceptance edge itself so a same-cycle write cannot leak into this check.
    password_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .i_wrEn   (wren),
        .i_wrAddr (wr_addr),
        .i_wrData (wr_data),
        .i_rdEn   (w_accept),
        .i_rdAddr (chk_addr),
        .o_rdData (w_ramQ)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the state-derived handshake and lock outputs.
    always_comb begin
        w_nextState = r_state;
        chk_ready   = 1'b0;
        locked      = 1'b0;
        case (r_state)
            IDLE: begin
                chk_ready = 1'b1;
                if (chk_valid) begin
                    w_nextState = READ;
                end
            end
            READ:   w_nextState = CMP;
            CMP:    w_nextState = RESULT;
            RESULT: w_nextState = (r_failCount == FAIL_MAX) ? LOCK : IDLE;
            LOCK: begin
                locked = 1'b1;
                if (r_lockCount == '0) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Provisioning marks entries valid; only reset clears them, the RAM words themselves are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (wren) begin
            r_valid[wr_addr] <= 1'b1;
        end
    end

    // Capture the request on acceptance so the comparison is immune to later input changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_addr <= chk_addr;
            r_data <= chk_data;
        end
    end

    // Result strobe: registered out of CMP so it is high for exactly the RESULT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resValid <= 1'b0;
            r_resMatch <= 1'b0;
        end else begin
            r_resValid <= (r_state == CMP);
            r_resMatch <= (r_state == CMP) && w_match;
        end
    end

    // Consecutive-failure counter: clears on a match or at lockout expiry, saturates at MAX_TRIES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_failCount <= '0;
        end else if (r_state == CMP) begin
            if (w_match) begin
                r_failCount <= '0;
            end else if (r_failCount != FAIL_MAX) begin
                r_failCount <= r_failCount + FAIL_W'(1);
            end
        end else if (w_lockDone) begin
            r_failCount <= '0;
        end
    end

    // Lockout down-counter: loaded on entry to LOCK so the lock lasts LOCK_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lockCount <= '0;
        end else if ((r_state == RESULT) && (w_nextState == LOCK)) begin
            r_lockCount <= LOCK_LOAD;
        end else if ((r_state == LOCK) && (r_lockCount != '0)) begin
            r_lockCount <= r_lockCount - LOCK_W'(1);
        end
    end

endmodule

// File: tb/tb_password_check.sv
// Directed testbench for password_check with hand-computed expectations.
module tb_password_check;

    logic        clk;
    logic        rst;
    logic        wren;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        chk_valid;
    logic        chk_ready;
    logic [3:0]  chk_addr;
    logic [15:0] chk_data;
    logic        res_valid;
    logic        res_match;
    logic        locked;
    logic [1:0]  fail_count;

    int testsRun    = 0;
    int testsFailed = 0;

    password_check #(
        .DATA_W      (16),
        .ADDR_W      (4),
        .MAX_TRIES   (3),
        .LOCK_CYCLES (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wren       (wren),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .chk_valid  (chk_valid),
        .chk_ready  (chk_ready),
        .chk_addr   (chk_addr),
        .chk_data   (chk_data),
        .res_valid  (res_valid),
        .res_match  (res_match),
        .locked     (locked),
        .fail_count (fail_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count the outcome.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive all request inputs at once.
    task automatic applyStimulus(input logic wr, input logic [3:0] wa, input logic [15:0] wd,
                                 input logic cv, input logic [3:0] ca, input logic [15:0] cd);
        wren      = wr;
        wr_addr   = wa;
        wr_data   = wd;
        chk_valid = cv;
        chk_addr  = ca;
        chk_data  = cd;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One provisioning write on the next edge.
    task automatic writeEntry(input logic [3:0] wa, input logic [15:0] wd);
        applyStimulus(1'b1, wa, wd, 1'b0, 4'd0, 16'd0);
        step();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    endtask

    // Full check transaction from IDLE, checking timing at E0..E0+3; optional same-edge write.
    task automatic runCheck(input string tag, input logic wr, input logic [3:0] wa, input logic [15:0] wd,
                            input logic [3:0] ca, input logic [15:0] cd,
                            input logic expMatch, input logic [1:0] expFail, input logic expLocked);
        checkOutput({tag, ".readyBefore"}, {31'd0, chk_ready}, 32'd1);
        applyStimulus(wr, wa, wd, 1'b1, ca, cd);
        step();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        checkOutput({tag, ".readyE0"}, {31'd0, chk_ready}, 32'd0);
        checkOutput({tag, ".resValidE0"}, {31'd0, res_valid}, 32'd0);
        step();
        checkOutput({tag, ".resValidE1"}, {31'd0, res_valid}, 32'd0);
        step();
        checkOutput({tag, ".resValidE2"}, {31'd0, res_valid}, 32'd1);
        checkOutput({tag, ".resMatch"}, {31'd0, res_match}, {31'd0, expMatch});
        checkOutput({tag, ".failCount"}, {30'd0, fail_count}, {30'd0, expFail});
        step();
        checkOutput({tag, ".resValidE3"}, {31'd0, res_valid}, 32'd0);
        checkOutput({tag, ".locked"}, {31'd0, locked}, {31'd0, expLocked});
        checkOutput({tag, ".readyE3"}, {31'd0, chk_ready}, {31'd0, ~expLocked});
    endtask

    // Check that every output is at its reset value.
    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".ready"}, {31'd0, chk_ready}, 32'd1);
        checkOutput({tag, ".resValid"}, {31'd0, res_valid}, 32'd0);
        checkOutput({tag, ".resMatch"}, {31'd0, res_match}, 32'd0);
        checkOutput({tag, ".locked"}, {31'd0, locked}, 32'd0);
        checkOutput({tag, ".failCount"}, {30'd0, fail_count}, 32'd0);
    endtask

    // Linear sequence of directed steps.
    initial begin
        logic lockBad;
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        step();
        step();
        rst = 1'b0;
        checkResetValues("reset");

        // Unprovisioned entry mismatches even if RAM held the value.
        runCheck("unwritten", 1'b0, 4'd0, 16'd0, 4'd3, 16'hAAAA, 1'b0, 2'd1, 1'b0);

        // Provision then match; fail count clears.
        writeEntry(4'd3, 16'hAAAA);
        runCheck("match3", 1'b0, 4'd0, 16'd0, 4'd3, 16'hAAAA, 1'b1, 2'd0, 1'b0);

        // Three mismatches drive lockout.
        writeEntry(4'd5, 16'h1476);
        runCheck("miss1", 1'b0, 4'd0, 16'd0, 4'd5, 16'h6435, 1'b0, 2'd1, 1'b0);
        runCheck("miss2", 1'b0, 4'd0, 16'd0, 4'd5, 16'h5095, 1'b0, 2'd2, 1'b0);
        runCheck("miss3", 1'b0, 4'd0, 16'd0, 4'd5, 16'h0000, 1'b0, 2'd3, 1'b1);

        // Hold a valid request through the lockout; it must never be served.
        lockBad = 1'b0;
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h1476);
        for (int i = 1; i < 1024; i++) begin
            step();
            if (res_valid || !locked || chk_ready) lockBad = 1'b1;
        end
        checkOutput("lock.held", {31'd0, lockBad}, 32'd0);
        checkOutput("lock.lastCycle", {31'd0, locked}, 32'd1);
        checkOutput("lock.failSat", {30'd0, fail_count}, 32'd3);
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        step();
        checkOutput("lock.released", {31'd0, locked}, 32'd0);
        checkOutput("lock.readyBack", {31'd0, chk_ready}, 32'd1);
        checkOutput("lock.failCleared", {30'd0, fail_count}, 32'd0);

        // Two misses then a match: no lockout, counter clears.
        runCheck("rec.miss1", 1'b0, 4'd0, 16'd0, 4'd5, 16'h0001, 1'b0, 2'd1, 1'b0);
        runCheck("rec.miss2", 1'b0, 4'd0, 16'd0, 4'd5, 16'h0002, 1'b0, 2'd2, 1'b0);
        runCheck("rec.match", 1'b0, 4'd0, 16'd0, 4'd5, 16'h1476, 1'b1, 2'd0, 1'b0);

        // Same-edge write and check: check sees old word, next check sees new word.
        runCheck("rf.old", 1'b1, 4'd5, 16'hBEEF, 4'd5, 16'h1476, 1'b1, 2'd0, 1'b0);
        runCheck("rf.new", 1'b0, 4'd0, 16'd0, 4'd5, 16'hBEEF, 1'b1, 2'd0, 1'b0);

        // Reset during READ aborts the check without a result.
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'hBEEF);
        step();
        applyStimulus(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkResetValues("rstRead");
        step();
        checkOutput("rstRead.noResult", {31'd0, res_valid}, 32'd0);
        runCheck("rstRead.invalid", 1'b0, 4'd0, 16'd0, 4'd5, 16'hBEEF, 1'b0, 2'd1, 1'b0);

        // Reach lockout again, then reset in the middle of it.
        runCheck("rstLock.miss2", 1'b0, 4'd0, 16'd0, 4'd5, 16'h0000, 1'b0, 2'd2, 1'b0);
        runCheck("rstLock.miss3", 1'b0, 4'd0, 16'd0, 4'd5, 16'h0000, 1'b0, 2'd3, 1'b1);
        for (int i = 0; i < 5; i++) step();
        checkOutput("rstLock.stillLocked", {31'd0, locked}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkResetValues("rstLock");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
